// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multi-cycle MIPS controller (master) and the
// datapath/ALU (slave): instruction fields and Zero in, enables and selects out.
interface multicycle_ctrl_if #(
  parameter int ALUCONF_W = 5
);
   logic [5:0]           OpCode;
   logic [5:0]           Funct;
   logic                 Zero;
   logic [1:0]           State;
   logic                 PCWrite;
   logic                 IRWrite;
   logic                 MemRead;
   logic                 MemWrite;
   logic                 RegWrite;
   logic [1:0]           RegDst;
   logic [1:0]           MemtoReg;
   logic [1:0]           ALUSrcA;
   logic [1:0]           ALUSrcB;
   logic                 ExtOp;
   logic                 LuiOp;
   logic [1:0]           PCSource;
   logic [ALUCONF_W-1:0] ALUConf;
   logic                 Sign;
   logic                 IllegalInst;

   modport master (
      input  OpCode, Funct, Zero,
      output State, PCWrite, IRWrite, MemRead, MemWrite, RegWrite, RegDst,
             MemtoReg, ALUSrcA, ALUSrcB, ExtOp, LuiOp, PCSource, ALUConf,
             Sign, IllegalInst
   );

   modport slave (
      output OpCode, Funct, Zero,
      input  State, PCWrite, IRWrite, MemRead, MemWrite, RegWrite, RegDst,
             MemtoReg, ALUSrcA, ALUSrcB, ExtOp, LuiOp, PCSource, ALUConf,
             Sign, IllegalInst
   );
endinterface

// File: rtl/multicycle_ctrl.sv
// Four-state (FETCH/DECODE/EXEC/WB) control FSM for the multi-cycle MIPS CPU.
// Optional ILLEGAL_TRAP_EN: undefined instructions trap through PCSource=3.
module multicycle_ctrl #(
   parameter int ALUCONF_W = 5
) (
   input  logic              clk,
   input  logic              reset,
   multicycle_ctrl_if.master bus
);

   typedef enum logic [1:0] {FETCH = 2'd0, DECODE = 2'd1, EXEC = 2'd2, WB = 2'd3} state_t;

   typedef enum logic [3:0] {
      C_RALU, C_SHIFT, C_IALU, C_LW, C_SW, C_J, C_JAL,
      C_BEQ, C_BNE, C_JR, C_JALR, C_UNDEF
   } iclass_t;

   localparam logic [ALUCONF_W-1:0] ALU_ADD   = ALUCONF_W'(0);
   localparam logic [ALUCONF_W-1:0] ALU_SUB   = ALUCONF_W'(1);
   localparam logic [ALUCONF_W-1:0] ALU_AND   = ALUCONF_W'(2);
   localparam logic [ALUCONF_W-1:0] ALU_OR    = ALUCONF_W'(3);
   localparam logic [ALUCONF_W-1:0] ALU_XOR   = ALUCONF_W'(4);
   localparam logic [ALUCONF_W-1:0] ALU_NOR   = ALUCONF_W'(5);
   localparam logic [ALUCONF_W-1:0] ALU_SL    = ALUCONF_W'(6);
   localparam logic [ALUCONF_W-1:0] ALU_SR    = ALUCONF_W'(7);
   localparam logic [ALUCONF_W-1:0] ALU_SLT   = ALUCONF_W'(8);
   localparam logic [ALUCONF_W-1:0] ALU_PASSB = ALUCONF_W'(16);

   state_t                 state, state_nx;
   iclass_t                iclass;
   logic [ALUCONF_W-1:0]   dec_conf;
   logic                   dec_sign, dec_ext, dec_lui;

   logic                   pc_write, ir_write, mem_read, mem_write, reg_write;
   logic [1:0]             reg_dst, mem_to_reg, alu_src_a, alu_src_b, pc_source;
   logic                   ext_op, lui_op, alu_sign;
   logic [ALUCONF_W-1:0]   alu_conf;
`ifdef ILLEGAL_TRAP_EN
   logic                   illegal;
`endif

   // Instruction class plus the EXEC-stage ALU setup for ALU-type instructions.
   always_comb begin
      // NOTE: every comb output gets a default first so no path infers a latch.
      iclass   = C_UNDEF;
      dec_conf = ALU_ADD;
      dec_sign = 1'b0;
      dec_ext  = 1'b1;
      dec_lui  = 1'b0;
      case (bus.OpCode)
         6'h00: begin
            case (bus.Funct)
               6'h00: begin iclass = C_SHIFT; dec_conf = ALU_SL; end
               6'h02: begin iclass = C_SHIFT; dec_conf = ALU_SR; end
               6'h03: begin iclass = C_SHIFT; dec_conf = ALU_SR; dec_sign = 1'b1; end
               6'h08: iclass = C_JR;
               6'h09: iclass = C_JALR;
               6'h20: begin iclass = C_RALU; dec_sign = 1'b1; end
               6'h21: iclass = C_RALU;
               6'h22: begin iclass = C_RALU; dec_conf = ALU_SUB; dec_sign = 1'b1; end
               6'h23: begin iclass = C_RALU; dec_conf = ALU_SUB; end
               6'h24: begin iclass = C_RALU; dec_conf = ALU_AND; end
               6'h25: begin iclass = C_RALU; dec_conf = ALU_OR;  end
               6'h26: begin iclass = C_RALU; dec_conf = ALU_XOR; end
               6'h27: begin iclass = C_RALU; dec_conf = ALU_NOR; end
               6'h2A: begin iclass = C_RALU; dec_conf = ALU_SLT; dec_sign = 1'b1; end
               6'h2B: begin iclass = C_RALU; dec_conf = ALU_SLT; end
               default: ;
            endcase
         end
         6'h02: iclass = C_J;
         6'h03: iclass = C_JAL;
         6'h04: iclass = C_BEQ;
         6'h05: iclass = C_BNE;
         6'h08, 6'h09: iclass = C_IALU;
         6'h0A: begin iclass = C_IALU; dec_conf = ALU_SLT; dec_sign = 1'b1; end
         6'h0B: begin iclass = C_IALU; dec_conf = ALU_SLT; end
         6'h0C: begin iclass = C_IALU; dec_conf = ALU_AND; dec_ext = 1'b0; end
         6'h0F: begin iclass = C_IALU; dec_conf = ALU_PASSB; dec_lui = 1'b1; end
         6'h23: iclass = C_LW;
         6'h2B: iclass = C_SW;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
      if (!reset) state <= FETCH;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = FETCH;
      case (state)
         FETCH:  state_nx = DECODE;
         DECODE: state_nx = (iclass inside {C_J, C_JAL, C_UNDEF}) ? FETCH : EXEC;
         EXEC:   state_nx = (iclass inside {C_BEQ, C_BNE, C_JR, C_JALR}) ? FETCH : WB;
         WB:     state_nx = FETCH;
         default: state_nx = FETCH;
      endcase
   end

   always_comb begin
      pc_write   = 1'b0;
      ir_write   = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      reg_write  = 1'b0;
      reg_dst    = 2'd0;
      mem_to_reg = 2'd0;
      alu_src_a  = 2'd0;
      alu_src_b  = 2'd0;
      pc_source  = 2'd0;
      ext_op     = 1'b1;
      lui_op     = 1'b0;
      alu_conf   = ALU_ADD;
      alu_sign   = 1'b0;
`ifdef ILLEGAL_TRAP_EN
      illegal    = 1'b0;
`endif
      case (state)
         FETCH: begin
            mem_read  = 1'b1;
            ir_write  = 1'b1;
            alu_src_b = 2'd1;
            pc_write  = 1'b1;
         end
         DECODE: begin
            // Branch target (PC+4 + sext imm<<2) is computed here into ALUOut.
            alu_src_b = 2'd3;
            case (iclass)
               C_J: begin pc_write = 1'b1; pc_source = 2'd2; end
               C_JAL: begin
                  pc_write   = 1'b1;
                  pc_source  = 2'd2;
                  reg_write  = 1'b1;
                  reg_dst    = 2'd2;
                  mem_to_reg = 2'd2;
               end
`ifdef ILLEGAL_TRAP_EN
               C_UNDEF: begin illegal = 1'b1; pc_write = 1'b1; pc_source = 2'd3; end
`endif
               default: ;
            endcase
         end
         EXEC: begin
            case (iclass)
               C_RALU, C_SHIFT: begin
                  alu_src_a = (iclass == C_SHIFT) ? 2'd2 : 2'd1;
                  alu_conf  = dec_conf;
                  alu_sign  = dec_sign;
               end
               C_IALU, C_LW, C_SW: begin
                  alu_src_a = 2'd1;
                  alu_src_b = 2'd2;
                  alu_conf  = dec_conf;
                  alu_sign  = dec_sign;
                  ext_op    = dec_ext;
                  lui_op    = dec_lui;
               end
               C_BEQ, C_BNE: begin
                  alu_src_a = 2'd1;
                  alu_conf  = ALU_SUB;
                  pc_source = 2'd1;
                  pc_write  = (iclass == C_BEQ) ? bus.Zero : ~bus.Zero;
               end
               C_JR, C_JALR: begin
                  pc_write  = 1'b1;
                  pc_source = 2'd3;
                  if (iclass == C_JALR) begin
                     reg_write  = 1'b1;
                     reg_dst    = 2'd1;
                     mem_to_reg = 2'd2;
                  end
               end
               default: ;
            endcase
         end
         WB: begin
            case (iclass)
               C_RALU, C_SHIFT: begin reg_write = 1'b1; reg_dst = 2'd1; end
               C_IALU:          reg_write = 1'b1;
               C_LW: begin mem_read = 1'b1; reg_write = 1'b1; mem_to_reg = 2'd1; end
               C_SW:            mem_write = 1'b1;
               default: ;
            endcase
         end
         default: ;
      endcase
   end

   // Write enables are gated by reset itself so nothing is written while it is held low.
   assign bus.PCWrite  = pc_write  & reset;
   assign bus.IRWrite  = ir_write  & reset;
   assign bus.MemWrite = mem_write & reset;
   assign bus.RegWrite = reg_write & reset;
   assign bus.State    = state;
   assign bus.MemRead  = mem_read;
   assign bus.RegDst   = reg_dst;
   assign bus.MemtoReg = mem_to_reg;
   assign bus.ALUSrcA  = alu_src_a;
   assign bus.ALUSrcB  = alu_src_b;
   assign bus.ExtOp    = ext_op;
   assign bus.LuiOp    = lui_op;
   assign bus.PCSource = pc_source;
   assign bus.ALUConf  = alu_conf;
   assign bus.Sign     = alu_sign;
`ifdef ILLEGAL_TRAP_EN
   assign bus.IllegalInst = illegal;
`else
   assign bus.IllegalInst = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed scenarios plus random
// instruction streams, checked every cycle against a table-driven model.
module tb_multicycle_ctrl;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   multicycle_ctrl_if ifc ();
   multicycle_ctrl dut (.clk(clk), .reset(reset), .bus(ifc));

`ifdef ILLEGAL_TRAP_EN
   localparam bit TRAP = 1'b1;
`else
   localparam bit TRAP = 1'b0;
`endif

   typedef struct packed {
      logic       pcw, irw, mr, mw, rw;
      logic [1:0] rd, m2r, sa, sb;
      logic       ext, lui;
      logic [1:0] ps;
      logic [4:0] conf;
      logic       sign, ill;
   } out_t;

   typedef enum int {K_RALU, K_IALU, K_LW, K_SW, K_J, K_JAL, K_BEQ, K_BNE, K_JR, K_JALR, K_NOP} kind_t;

   typedef struct {
      string      name;
      logic [5:0] op, fn;
      kind_t      kind;
      logic [1:0] sa;
      logic [4:0] conf;
      logic       sign, ext, lui;
   } desc_t;

   desc_t tbl[$];
   int    checks = 0;
   int    errors = 0;

   function automatic desc_t mk(string n, logic [5:0] op, logic [5:0] fn, kind_t k,
                                logic [1:0] sa, logic [4:0] conf, logic sign, logic ext, logic lui);
      desc_t d;
      d.name = n; d.op = op; d.fn = fn; d.kind = k; d.sa = sa;
      d.conf = conf; d.sign = sign; d.ext = ext; d.lui = lui;
      return d;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic desc_t lookup(logic [5:0] op, logic [5:0] fn);
      foreach (tbl[i])
         if (tbl[i].op == op && (op != 6'h00 || tbl[i].fn == fn)) return tbl[i];
      return mk("undef", op, fn, K_NOP, 2'd0, 5'd0, 1'b0, 1'b1, 1'b0);
   endfunction

   function automatic int latency(kind_t k);
      if (k inside {K_J, K_JAL, K_NOP}) return 2;
      if (k inside {K_BEQ, K_BNE, K_JR, K_JALR}) return 3;
      return 4;
   endfunction

   // Expected control word for cycle 'step' (0 = FETCH) of instruction d.
   function automatic out_t model(desc_t d, int step, logic z);
      out_t o = '0;
      o.ext = 1'b1;
      if (step == 0) begin
         o.mr = 1'b1; o.irw = 1'b1; o.sb = 2'd1; o.pcw = 1'b1;
      end else if (step == 1) begin
         o.sb = 2'd3;
         if (d.kind == K_J || d.kind == K_JAL) begin o.pcw = 1'b1; o.ps = 2'd2; end
         if (d.kind == K_JAL) begin o.rw = 1'b1; o.rd = 2'd2; o.m2r = 2'd2; end
         if (d.kind == K_NOP && TRAP) begin o.ill = 1'b1; o.pcw = 1'b1; o.ps = 2'd3; end
      end else if (step == 2) begin
         if (d.kind == K_BEQ || d.kind == K_BNE) begin
            o.sa = 2'd1; o.conf = 5'd1; o.ps = 2'd1;
            o.pcw = (d.kind == K_BEQ) ? z : !z;
         end else if (d.kind == K_JR || d.kind == K_JALR) begin
            o.pcw = 1'b1; o.ps = 2'd3;
            if (d.kind == K_JALR) begin o.rw = 1'b1; o.rd = 2'd1; o.m2r = 2'd2; end
         end else begin
            o.sa = d.sa; o.sb = (d.kind == K_RALU) ? 2'd0 : 2'd2;
            o.conf = d.conf; o.sign = d.sign; o.ext = d.ext; o.lui = d.lui;
         end
      end else begin
         case (d.kind)
            K_RALU: begin o.rw = 1'b1; o.rd = 2'd1; end
            K_IALU: o.rw = 1'b1;
            K_LW:   begin o.mr = 1'b1; o.rw = 1'b1; o.m2r = 2'd1; end
            K_SW:   o.mw = 1'b1;
            default: ;
         endcase
      end
      return o;
   endfunction

   function automatic out_t observe();
      out_t o;
      o.pcw = ifc.PCWrite; o.irw = ifc.IRWrite; o.mr = ifc.MemRead; o.mw = ifc.MemWrite;
      o.rw = ifc.RegWrite; o.rd = ifc.RegDst; o.m2r = ifc.MemtoReg; o.sa = ifc.ALUSrcA;
      o.sb = ifc.ALUSrcB; o.ext = ifc.ExtOp; o.lui = ifc.LuiOp; o.ps = ifc.PCSource;
      o.conf = ifc.ALUConf; o.sign = ifc.Sign; o.ill = ifc.IllegalInst;
      return o;
   endfunction

   function automatic out_t reset_out();
      desc_t d = lookup(6'h00, 6'h20);
      out_t  o = model(d, 0, 1'b0);
      o.pcw = 1'b0; o.irw = 1'b0;
      return o;
   endfunction

   // Caller must be in FETCH, before the negedge of that cycle.
   task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int zmode,
                            input int max_steps);
      desc_t d = lookup(op, fn);
      int    n = latency(d.kind);
      if (max_steps < n) n = max_steps;
      for (int s = 0; s < n; s++) begin
         @(negedge clk);
         ifc.OpCode = (s == 0) ? 6'($urandom) : op;
         ifc.Funct  = (s == 0) ? 6'($urandom) : fn;
         ifc.Zero   = (zmode < 0) ? 1'($urandom) : 1'(zmode);
         #1;
         check($sformatf("%s s%0d state", d.name, s), 32'(ifc.State), 32'(s));
         check($sformatf("%s s%0d ctrl", d.name, s), 32'(observe()), 32'(model(d, s, ifc.Zero)));
      end
   endtask

   initial begin
      tbl.push_back(mk("add",   6'h00, 6'h20, K_RALU, 2'd1, 5'd0, 1, 1, 0));
      tbl.push_back(mk("addu",  6'h00, 6'h21, K_RALU, 2'd1, 5'd0, 0, 1, 0));
      tbl.push_back(mk("sub",   6'h00, 6'h22, K_RALU, 2'd1, 5'd1, 1, 1, 0));
      tbl.push_back(mk("subu",  6'h00, 6'h23, K_RALU, 2'd1, 5'd1, 0, 1, 0));
      tbl.push_back(mk("and",   6'h00, 6'h24, K_RALU, 2'd1, 5'd2, 0, 1, 0));
      tbl.push_back(mk("or",    6'h00, 6'h25, K_RALU, 2'd1, 5'd3, 0, 1, 0));
      tbl.push_back(mk("xor",   6'h00, 6'h26, K_RALU, 2'd1, 5'd4, 0, 1, 0));
      tbl.push_back(mk("nor",   6'h00, 6'h27, K_RALU, 2'd1, 5'd5, 0, 1, 0));
      tbl.push_back(mk("slt",   6'h00, 6'h2A, K_RALU, 2'd1, 5'd8, 1, 1, 0));
      tbl.push_back(mk("sltu",  6'h00, 6'h2B, K_RALU, 2'd1, 5'd8, 0, 1, 0));
      tbl.push_back(mk("sll",   6'h00, 6'h00, K_RALU, 2'd2, 5'd6, 0, 1, 0));
      tbl.push_back(mk("srl",   6'h00, 6'h02, K_RALU, 2'd2, 5'd7, 0, 1, 0));
      tbl.push_back(mk("sra",   6'h00, 6'h03, K_RALU, 2'd2, 5'd7, 1, 1, 0));
      tbl.push_back(mk("jr",    6'h00, 6'h08, K_JR,   2'd0, 5'd0, 0, 1, 0));
      tbl.push_back(mk("jalr",  6'h00, 6'h09, K_JALR, 2'd0, 5'd0, 0, 1, 0));
      tbl.push_back(mk("j",     6'h02, 6'h00, K_J,    2'd0, 5'd0, 0, 1, 0));
      tbl.push_back(mk("jal",   6'h03, 6'h00, K_JAL,  2'd0, 5'd0, 0, 1, 0));
      tbl.push_back(mk("beq",   6'h04, 6'h00, K_BEQ,  2'd0, 5'd0, 0, 1, 0));
      tbl.push_back(mk("bne",   6'h05, 6'h00, K_BNE,  2'd0, 5'd0, 0, 1, 0));
      tbl.push_back(mk("addi",  6'h08, 6'h00, K_IALU, 2'd1, 5'd0, 0, 1, 0));
      tbl.push_back(mk("addiu", 6'h09, 6'h00, K_IALU, 2'd1, 5'd0, 0, 1, 0));
      tbl.push_back(mk("slti",  6'h0A, 6'h00, K_IALU, 2'd1, 5'd8, 1, 1, 0));
      tbl.push_back(mk("sltiu", 6'h0B, 6'h00, K_IALU, 2'd1, 5'd8, 0, 1, 0));
      tbl.push_back(mk("andi",  6'h0C, 6'h00, K_IALU, 2'd1, 5'd2, 0, 0, 0));
      tbl.push_back(mk("lui",   6'h0F, 6'h00, K_IALU, 2'd1, 5'h10, 0, 1, 1));
      tbl.push_back(mk("lw",    6'h23, 6'h00, K_LW,   2'd1, 5'd0, 0, 1, 0));
      tbl.push_back(mk("sw",    6'h2B, 6'h00, K_SW,   2'd1, 5'd0, 0, 1, 0));

      reset = 1'b0;
      ifc.OpCode = 6'h00; ifc.Funct = 6'h20; ifc.Zero = 1'b0;
      #3;
      check("reset state", 32'(ifc.State), 32'd0);
      check("reset ctrl", 32'(observe()), 32'(reset_out()));
      @(posedge clk); #1;
      check("reset hold state", 32'(ifc.State), 32'd0);
      #1 reset = 1'b1;

      run_instr(6'h00, 6'h20, -1, 4);  // add
      run_instr(6'h04, 6'h00,  1, 4);  // beq taken
      run_instr(6'h04, 6'h00,  0, 4);  // beq not taken
      run_instr(6'h05, 6'h00,  1, 4);  // bne not taken
      run_instr(6'h00, 6'h03, -1, 4);  // sra
      run_instr(6'h00, 6'h02, -1, 4);  // srl
      run_instr(6'h23, 6'h00, -1, 4);  // lw
      run_instr(6'h2B, 6'h00, -1, 4);  // sw
      run_instr(6'h0F, 6'h00, -1, 4);  // lui
      run_instr(6'h03, 6'h00, -1, 4);  // jal
      run_instr(6'h00, 6'h09, -1, 4);  // jalr
      run_instr(6'h3F, 6'h00, -1, 4);  // undefined opcode
      run_instr(6'h00, 6'h3F, -1, 4);  // undefined funct

      // Abort sw in EXEC: FETCH at once, no write at any point while reset is low.
      run_instr(6'h2B, 6'h00, -1, 3);
      reset = 1'b0;
      #1;
      check("abort state", 32'(ifc.State), 32'd0);
      check("abort ctrl", 32'(observe()), 32'(reset_out()));
      @(posedge clk); #1;
      check("abort edge state", 32'(ifc.State), 32'd0);
      check("abort memwrite", 32'(ifc.MemWrite), 32'd0);
      @(posedge clk); #2 reset = 1'b1;
      run_instr(6'h2B, 6'h00, -1, 4);

      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(4, 0) != 0) begin
            int k = $urandom_range(tbl.size() - 1, 0);
            run_instr(tbl[k].op, tbl[k].fn, -1, 4);
         end else begin
            run_instr(6'($urandom), 6'($urandom), -1, 4);
         end
      end

      @(negedge clk); #1;
      check("final state", 32'(ifc.State), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Control FSM for the 4-state multi-cycle MIPS CPU. Sits on the controlling side of the ALU interface.
- Decodes OpCode/Funct from the instruction register and drives ALUConf/Sign into the ALU.
- Consumes the ALU's Zero flag to resolve branches.
- Sequences FETCH -> DECODE -> EXEC -> WB and generates every datapath enable and mux select.

Parameters:
- ALUCONF_W, 5, ALUConf width; fixed to match the ALU.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset
- OpCode  input  6  IR[31:26]
- Funct  input  6  IR[5:0]
- Zero  input  1  ALU Zero flag (Result==0)
- State  output  2  current state: 0 FETCH, 1 DECODE, 2 EXEC, 3 WB
- PCWrite  output  1  PC load enable; branch condition already folded in
- IRWrite  output  1  IR load enable
- MemRead  output  1  memory read
- MemWrite  output  1  memory write
- RegWrite  output  1  register-file write
- RegDst  output  2  write register: 0 rt, 1 rd, 2 $31
- MemtoReg  output  2  write data: 0 ALUOut, 1 MDR, 2 PC
- ALUSrcA  output  2  In1: 0 PC, 1 reg A, 2 shamt
- ALUSrcB  output  2  In2: 0 reg B, 1 const 4, 2 ext imm, 3 sext imm<<2
- ExtOp  output  1  1 sign-extend, 0 zero-extend
- LuiOp  output  1  imm<<16 select
- PCSource  output  2  0 ALU Result, 1 ALUOut reg, 2 jump target, 3 reg A
- ALUConf  output  5  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR, 6 SL, 7 SR, 8 SLT, 9 pass In1, 5'h10 pass In2
- Sign  output  1  signed SLT / arithmetic SR
- IllegalInst  output  1  undefined-instruction pulse (optional feature only)

Behaviour:
- State register: 2 bits, reset to FETCH asynchronously on reset low.
- Outputs are combinational from State, OpCode and Funct (plus Zero for PCWrite).
- While reset is low, all write enables (PCWrite, IRWrite, MemWrite, RegWrite) are forced 0. All other outputs take their FETCH values.
- Defaults in every state unless listed: enables 0; selects 0; ALUConf=ADD; Sign=0; ExtOp=1; LuiOp=0.
- FETCH:
  - MemRead=1, IRWrite=1, ALUSrcA=0, ALUSrcB=1, ALUConf=ADD, PCSource=0, PCWrite=1.
  - Next state DECODE.
- DECODE:
  - ALUSrcA=0, ALUSrcB=3, ALUConf=ADD (branch target into ALUOut).
  - j: PCWrite=1, PCSource=2, next FETCH.
  - jal: as j, plus RegWrite=1, RegDst=2, MemtoReg=2; next FETCH.
  - All other defined instructions: next EXEC.
- EXEC:
  - R-type: ALUSrcA=1 (2 for sll/srl/sra), ALUSrcB=0.
    - ALUConf by Funct: add/addu ADD, sub/subu SUB, and AND, or OR, xor XOR, nor NOR, slt/sltu SLT, sll SL, srl/sra SR.
    - Sign=1 for add, sub, slt, sra; Sign=0 for addu, subu, sltu, srl.
  - I-type: ALUSrcA=1, ALUSrcB=2.
    - addi/addiu/lw/sw ADD, ExtOp=1.
    - andi AND, ExtOp=0.
    - slti SLT with Sign=1; sltiu SLT with Sign=0.
    - lui: pass In2 (5'h10), LuiOp=1.
  - beq/bne: ALUSrcA=1, ALUSrcB=0, ALUConf=SUB, PCSource=1.
    - PCWrite = Zero for beq, ~Zero for bne.
    - Next FETCH.
  - jr: PCWrite=1, PCSource=3, next FETCH.
  - jalr: as jr, plus RegWrite=1, RegDst=1, MemtoReg=2; next FETCH.
  - All others: next WB.
- WB:
  - R-type: RegWrite=1, RegDst=1, MemtoReg=0.
  - I-type ALU ops: RegWrite=1, RegDst=0, MemtoReg=0.
  - lw: MemRead=1, RegWrite=1, RegDst=0, MemtoReg=1.
  - sw: MemWrite=1.
  - Next FETCH.
- Latency in cycles: j/jal 2; beq/bne/jr/jalr 3; all others 4.
- Reset asserted mid-instruction: abort immediately and restart in FETCH on release. No partial write is issued once reset is low.
- Undefined OpCode/Funct without the optional feature: treated as NOP. DECODE -> FETCH, no writes.

Optional Feature:
- Macro: ILLEGAL_TRAP_EN.
- Defined: an undefined instruction in DECODE asserts IllegalInst=1 for that single cycle, PCWrite=1, PCSource=3. The datapath's reg-A mux carries the exception vector when IllegalInst=1. Next state FETCH.
- Undefined: the IllegalInst port is tied 0 and undefined instructions behave as NOP.

Test Plan:
- Reset low, then release; run add (Op 0, Funct 0x20) -> State 0,1,2,3,0. EXEC ALUConf=0, Sign=1. WB RegWrite=1, RegDst=1.
- Run beq (Op 0x04) with Zero=1, then with Zero=0 -> EXEC ALUConf=1, PCSource=1. PCWrite=1 in the first run, 0 in the second. Next state FETCH after 3 cycles.
- Run sra (Funct 0x03), then srl (Funct 0x02) -> ALUSrcA=2, ALUConf=7. Sign=1 for sra, 0 for srl.
- Run lw (0x23), sw (0x2B), lui (0x0F) -> lw: WB MemtoReg=1, RegWrite=1. sw: WB MemWrite=1. lui: ALUConf=5'h10, LuiOp=1.
- Run jal (0x03) -> DECODE PCWrite=1, PCSource=2, RegDst=2, MemtoReg=2. Next state FETCH (2 cycles).
- Pull reset low during EXEC of sw -> State=0 immediately, MemWrite never asserted. With ILLEGAL_TRAP_EN, Op 0x3F -> IllegalInst 1-cycle pulse in DECODE.
